// File: rtl/msrv32_lsu_ctrl.sv
// rtl/msrv32_lsu_ctrl.sv - msrv32 load/store sequencer, one outstanding data-bus access
// Optional feature macro: LSU_TIMEOUT_EN (WAIT-state response timeout after TIMEOUT cycles)
module msrv32_lsu_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        is_load_in,
  input  logic        is_store_in,
  input  logic [1:0]  load_size_in,
  input  logic        load_unsigned_in,
  input  logic        misaligned_load_in,
  input  logic        misaligned_store_in,
  input  logic        trap_taken_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  output logic        bus_req_out,
  output logic        bus_we_out,
  output logic [31:0] bus_addr_out,
  output logic [31:0] bus_wdata_out,
  output logic [3:0]  bus_wstrb_out,
  input  logic        bus_gnt_in,
  input  logic        bus_rvalid_in,
  input  logic [31:0] bus_rdata_in,
  input  logic        bus_err_in,
  output logic        stall_out,
  output logic [31:0] ld_data_out,
  output logic        ld_valid_out,
  output logic        load_fault_out,
  output logic        store_fault_out
);

  if (TIMEOUT < 2) begin : g_timeout_check
    $error("msrv32_lsu_ctrl: TIMEOUT must be >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic        start;
  logic [31:0] shifted;
  logic [31:0] ld_ext;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
`endif

  assign start = (is_load_in | is_store_in) & ~misaligned_load_in
               & ~misaligned_store_in & ~trap_taken_in;

  // Lane extraction uses the captured address; response data is not held past this cycle.
  always_comb begin
    shifted = bus_rdata_in >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'b00:   ld_ext = unsigned_q ? {24'h0, shifted[7:0]}
                                   : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   ld_ext = unsigned_q ? {16'h0, shifted[15:0]}
                                   : {{16{shifted[15]}}, shifted[15:0]};
      default: ld_ext = shifted;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    we_d       = we_q;
    err_d      = err_q;
    ld_data_d  = ld_data_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d      = cnt_q;
    to_d       = to_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_REQ;
          addr_d     = addr_in;
          size_d     = load_size_in;
          unsigned_d = load_unsigned_in;
          we_d       = is_store_in;
          err_d      = 1'b0;
          case (load_size_in)
            2'b00: begin
              wdata_d = {4{store_data_in[7:0]}};
              wstrb_d = 4'b0001 << addr_in[1:0];
            end
            2'b01: begin
              wdata_d = {2{store_data_in[15:0]}};
              wstrb_d = 4'b0011 << {addr_in[1], 1'b0};
            end
            default: begin
              wdata_d = store_data_in;
              wstrb_d = 4'hF;
            end
          endcase
          if (!is_store_in) wstrb_d = 4'h0;
        end
      end
      S_REQ: begin
        if (bus_gnt_in) begin
          state_d = trap_taken_in ? S_DRAIN : S_WAIT;
`ifdef LSU_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else if (trap_taken_in) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
`ifdef LSU_TIMEOUT_EN
        cnt_d = cnt_q + CNT_W'(1);
`endif
        if (bus_rvalid_in) begin
          state_d = S_RESP;
          err_d   = bus_err_in;
          if (!we_q && !bus_err_in) ld_data_d = ld_ext;
        end else if (trap_taken_in) begin
          state_d = S_DRAIN;
        end
`ifdef LSU_TIMEOUT_EN
        // Timed-out access reports a fault, then still absorbs the late response.
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          to_d    = 1'b1;
        end
`endif
      end
      S_DRAIN: begin
        if (bus_rvalid_in) state_d = S_IDLE;
      end
      S_RESP: begin
`ifdef LSU_TIMEOUT_EN
        state_d = to_q ? S_DRAIN : S_IDLE;
        to_d    = 1'b0;
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      size_q     <= '0;
      unsigned_q <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      ld_data_q  <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt_q      <= '0;
      to_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      we_q       <= we_d;
      err_q      <= err_d;
      ld_data_q  <= ld_data_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q      <= cnt_d;
      to_q       <= to_d;
`endif
    end
  end

  assign bus_req_out     = (state_q == S_REQ);
  assign bus_we_out      = we_q;
  assign bus_addr_out    = {addr_q[31:2], 2'b00};
  assign bus_wdata_out   = wdata_q;
  assign bus_wstrb_out   = wstrb_q;
  assign stall_out       = ((state_q == S_IDLE) & start) | (state_q == S_REQ)
                         | (state_q == S_WAIT) | (state_q == S_DRAIN);
  assign ld_data_out     = ld_data_q;
  assign ld_valid_out    = (state_q == S_RESP) & ~we_q & ~err_q;
  assign load_fault_out  = (state_q == S_RESP) & ~we_q & err_q;
  assign store_fault_out = (state_q == S_RESP) & we_q & err_q;

endmodule

// File: tb/tb_msrv32_lsu_ctrl.sv
// tb/tb_msrv32_lsu_ctrl.sv - directed and randomized bench for msrv32_lsu_ctrl
// Expected values come from byte-lane arithmetic on the load/store rules.
module tb_msrv32_lsu_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        is_load_in, is_store_in;
  logic [1:0]  load_size_in;
  logic        load_unsigned_in;
  logic        misaligned_load_in, misaligned_store_in;
  logic        trap_taken_in;
  logic [31:0] addr_in, store_data_in;
  logic        bus_req_out, bus_we_out;
  logic [31:0] bus_addr_out, bus_wdata_out;
  logic [3:0]  bus_wstrb_out;
  logic        bus_gnt_in, bus_rvalid_in, bus_err_in;
  logic [31:0] bus_rdata_in;
  logic        stall_out;
  logic [31:0] ld_data_out;
  logic        ld_valid_out, load_fault_out, store_fault_out;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_ld = 32'h0;

  always #5 clk_in = ~clk_in;

  msrv32_lsu_ctrl #(.TIMEOUT(4)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .is_load_in(is_load_in), .is_store_in(is_store_in),
    .load_size_in(load_size_in), .load_unsigned_in(load_unsigned_in),
    .misaligned_load_in(misaligned_load_in), .misaligned_store_in(misaligned_store_in),
    .trap_taken_in(trap_taken_in), .addr_in(addr_in), .store_data_in(store_data_in),
    .bus_req_out(bus_req_out), .bus_we_out(bus_we_out), .bus_addr_out(bus_addr_out),
    .bus_wdata_out(bus_wdata_out), .bus_wstrb_out(bus_wstrb_out),
    .bus_gnt_in(bus_gnt_in), .bus_rvalid_in(bus_rvalid_in),
    .bus_rdata_in(bus_rdata_in), .bus_err_in(bus_err_in),
    .stall_out(stall_out), .ld_data_out(ld_data_out), .ld_valid_out(ld_valid_out),
    .load_fault_out(load_fault_out), .store_fault_out(store_fault_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input bit [1:0] sz);
    return (sz == 2'b11) ? 4 : (1 << sz);
  endfunction

  function automatic logic [3:0] model_strb(input bit st, input bit [1:0] sz, input bit [31:0] a);
    int n = nbytes(sz);
    int off = int'(a % 4) / n * n;
    if (!st) return 4'h0;
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] model_wdata(input bit [1:0] sz, input bit [31:0] sd);
    logic [31:0] r;
    int n = nbytes(sz);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input bit [1:0] sz, input bit uns,
                                             input bit [31:0] a, input bit [31:0] rd);
    int n = nbytes(sz);
    longint v = longint'(rd >> (8 * int'(a % 4)));
    if (n < 4) begin
      v = v % (longint'(1) << (8 * n));
      if (!uns && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    end
    return 32'(v);
  endfunction

  task automatic idle_inputs();
    is_load_in = 0; is_store_in = 0; load_size_in = 0; load_unsigned_in = 0;
    misaligned_load_in = 0; misaligned_store_in = 0; trap_taken_in = 0;
    addr_in = 0; store_data_in = 0; bus_gnt_in = 0; bus_rvalid_in = 0;
    bus_err_in = 0; bus_rdata_in = 0;
  endtask

  task automatic drive_start(input bit st, input bit [1:0] sz, input bit uns,
                             input bit [31:0] a, input bit [31:0] sd);
    is_load_in = !st; is_store_in = st; load_size_in = sz;
    load_unsigned_in = uns; addr_in = a; store_data_in = sd;
  endtask

  task automatic drop_start();
    is_load_in = 0; is_store_in = 0; addr_in = $urandom; store_data_in = $urandom;
    load_size_in = 2'($urandom_range(0, 3)); load_unsigned_in = 1'($urandom_range(0, 1));
  endtask

  // Full transaction: gd idle REQ cycles before grant, rd WAIT cycles before response.
  task automatic run_txn(input bit st, input bit [1:0] sz, input bit uns, input bit [31:0] a,
                         input bit [31:0] sd, input int gd, input int rd,
                         input bit er, input bit [31:0] rdat);
    @(negedge clk_in);
    drive_start(st, sz, uns, a, sd);
    #1 chk("start_stall", stall_out, 1);
    chk("start_no_req", bus_req_out, 0);
    for (int c = 0; c <= gd; c++) begin
      @(negedge clk_in);
      drop_start();
      bus_gnt_in = (c == gd);
      #1 chk("req", bus_req_out, 1);
      chk("req_stall", stall_out, 1);
      chk("req_addr", bus_addr_out, {a[31:2], 2'b00});
      chk("req_we", bus_we_out, st);
      chk("req_wstrb", bus_wstrb_out, model_strb(st, sz, a));
      if (st) chk("req_wdata", bus_wdata_out, model_wdata(sz, sd));
    end
    for (int c = 0; c <= rd; c++) begin
      @(negedge clk_in);
      bus_gnt_in = 0;
      bus_rvalid_in = (c == rd);
      bus_rdata_in = (c == rd) ? rdat : $urandom;
      bus_err_in = (c == rd) ? er : 1'($urandom_range(0, 1));
      #1 chk("wait_stall", stall_out, 1);
      chk("wait_no_req", bus_req_out, 0);
      chk("wait_no_valid", ld_valid_out, 0);
    end
    if (!st && !er) exp_ld = model_load(sz, uns, a, rdat);
    @(negedge clk_in);
    bus_rvalid_in = 0; bus_err_in = 0;
    #1 chk("resp_stall", stall_out, 0);
    chk("resp_ld_valid", ld_valid_out, !st && !er);
    chk("resp_load_fault", load_fault_out, !st && er);
    chk("resp_store_fault", store_fault_out, st && er);
    chk("resp_ld_data", ld_data_out, exp_ld);
    @(negedge clk_in);
    #1 chk("after_ld_valid", ld_valid_out, 0);
    chk("after_faults", {30'h0, load_fault_out, store_fault_out}, 0);
    chk("after_stall", stall_out, 0);
    chk("after_ld_data", ld_data_out, exp_ld);
  endtask

  bit          r_st, r_uns, r_er;
  bit [1:0]    r_sz;
  bit [31:0]   r_a;

  initial begin
    idle_inputs();
    rst_n_in = 0;
    #12;
    chk("rst_req", bus_req_out, 0);
    chk("rst_stall", stall_out, 0);
    chk("rst_addr", bus_addr_out, 0);
    chk("rst_wdata", bus_wdata_out, 0);
    chk("rst_wstrb", bus_wstrb_out, 0);
    chk("rst_we", bus_we_out, 0);
    chk("rst_ld_data", ld_data_out, 0);
    chk("rst_pulses", {29'h0, ld_valid_out, load_fault_out, store_fault_out}, 0);
    @(negedge clk_in);
    rst_n_in = 1;

    run_txn(0, 2'b00, 0, 32'h0000_1003, 32'h0, 0, 0, 0, 32'h80FF_1234);
    chk("lb_value", ld_data_out, 32'hFFFF_FF80);
    run_txn(0, 2'b01, 1, 32'h0000_2002, 32'h0, 0, 0, 0, 32'hBEEF_0000);
    chk("lhu_value", ld_data_out, 32'h0000_BEEF);
    run_txn(1, 2'b00, 0, 32'h0000_3001, 32'h0000_00A5, 3, 1, 0, 32'h0);
    run_txn(1, 2'b10, 0, 32'h0000_4008, 32'h1234_5678, 0, 0, 1, 32'h0);

    // Trap while waiting: response is drained with no pulse
    @(negedge clk_in); drive_start(0, 2'b10, 0, 32'h0000_5000, 32'h0);
    @(negedge clk_in); drop_start(); bus_gnt_in = 1;
    @(negedge clk_in); bus_gnt_in = 0; trap_taken_in = 1;
    #1 chk("trapw_stall", stall_out, 1);
    @(negedge clk_in); trap_taken_in = 0;
    #1 chk("drain_stall", stall_out, 1);
    chk("drain_no_req", bus_req_out, 0);
    @(negedge clk_in); bus_rvalid_in = 1; bus_err_in = 1; bus_rdata_in = $urandom;
    #1 chk("drain_rv_stall", stall_out, 1);
    @(negedge clk_in); bus_rvalid_in = 0; bus_err_in = 0;
    #1 chk("drain_done_stall", stall_out, 0);
    chk("drain_pulses", {29'h0, ld_valid_out, load_fault_out, store_fault_out}, 0);
    chk("drain_ld_data", ld_data_out, exp_ld);

    // Trap in REQ without grant abandons; trap with grant drains
    @(negedge clk_in); drive_start(0, 2'b00, 0, 32'h0000_6000, 32'h0);
    @(negedge clk_in); drop_start(); trap_taken_in = 1;
    @(negedge clk_in); trap_taken_in = 0;
    #1 chk("trapreq_idle_req", bus_req_out, 0);
    chk("trapreq_idle_stall", stall_out, 0);
    @(negedge clk_in); drive_start(1, 2'b10, 0, 32'h0000_7000, 32'h0);
    @(negedge clk_in); drop_start(); trap_taken_in = 1; bus_gnt_in = 1;
    @(negedge clk_in); trap_taken_in = 0; bus_gnt_in = 0; bus_rvalid_in = 1; bus_err_in = 1;
    #1 chk("trapgnt_drain_stall", stall_out, 1);
    @(negedge clk_in); bus_rvalid_in = 0; bus_err_in = 0;
    #1 chk("trapgnt_no_fault", store_fault_out, 0);
    chk("trapgnt_stall", stall_out, 0);

    // Misaligned accesses and stray responses never touch the bus
    @(negedge clk_in); is_load_in = 1; misaligned_load_in = 1; addr_in = 32'h0000_0001;
    #1 chk("mis_ld_stall", stall_out, 0);
    @(negedge clk_in); is_load_in = 0; misaligned_load_in = 0;
    is_store_in = 1; misaligned_store_in = 1;
    #1 chk("mis_ld_req", bus_req_out, 0);
    chk("mis_st_stall", stall_out, 0);
    @(negedge clk_in); is_store_in = 0; misaligned_store_in = 0;
    bus_rvalid_in = 1; bus_err_in = 1;
    #1 chk("mis_st_req", bus_req_out, 0);
    @(negedge clk_in); bus_rvalid_in = 0; bus_err_in = 0;
    #1 chk("stray_pulses", {29'h0, ld_valid_out, load_fault_out, store_fault_out}, 0);

    for (int i = 0; i < 40; i++) begin
      r_st  = 1'($urandom_range(0, 1));
      r_sz  = 2'($urandom_range(0, 3));
      r_uns = 1'($urandom_range(0, 1));
      r_er  = ($urandom_range(0, 7) == 0);
      r_a   = $urandom & ~32'(nbytes(r_sz) - 1);
      run_txn(r_st, r_sz, r_uns, r_a, $urandom, $urandom_range(0, 3),
              $urandom_range(0, 3), r_er, $urandom);
    end

`ifdef LSU_TIMEOUT_EN
    @(negedge clk_in); drive_start(0, 2'b10, 0, 32'h0000_8000, 32'h0);
    @(negedge clk_in); drop_start(); bus_gnt_in = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_in); bus_gnt_in = 0;
      #1 chk("to_wait_stall", stall_out, 1);
      chk("to_wait_fault", load_fault_out, 0);
    end
    @(negedge clk_in);
    #1 chk("to_fault", load_fault_out, 1);
    chk("to_resp_stall", stall_out, 0);
    chk("to_no_valid", ld_valid_out, 0);
    @(negedge clk_in); bus_rvalid_in = 1;
    #1 chk("to_drain_stall", stall_out, 1);
    @(negedge clk_in); bus_rvalid_in = 0;
    #1 chk("to_done_stall", stall_out, 0);
    chk("to_done_fault", load_fault_out, 0);
`endif

    // Asynchronous reset mid-request
    @(negedge clk_in); drive_start(0, 2'b10, 0, 32'h0000_9000, 32'h0);
    @(negedge clk_in); drop_start();
    #1 chk("prerst_req", bus_req_out, 1);
    rst_n_in = 0;
    #1 chk("midrst_req", bus_req_out, 0);
    chk("midrst_stall", stall_out, 0);
    chk("midrst_ld_data", ld_data_out, 0);
    @(negedge clk_in); rst_n_in = 1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/msrv32_lsu_ctrl.md
Name: msrv32_lsu_ctrl

Overview:
Load/store sequencer for msrv32. Accepts the decoder's load/store classification, size, signedness and misalignment flags, plus the computed effective address. Runs a single-outstanding data-bus transaction (request/grant, then response) and stalls the core until the transaction completes. Returns aligned, sign- or zero-extended load data to the writeback mux, and flags bus errors as access faults to the trap unit.

Parameters:
TIMEOUT, 16, cycles spent in WAIT before an access fault is raised (used only with LSU_TIMEOUT_EN); must be ≥2.

Ports:
clk_in  input  1  core clock, rising edge
rst_n_in  input  1  asynchronous active-low reset
is_load_in  input  1  current instruction is LOAD
is_store_in  input  1  current instruction is STORE
load_size_in  input  2  funct3[1:0]: 00 byte, 01 half, 10 word
load_unsigned_in  input  1  funct3[2]: zero-extend load
misaligned_load_in  input  1  decoder misaligned-load flag
misaligned_store_in  input  1  decoder misaligned-store flag
trap_taken_in  input  1  trap/flush this cycle
addr_in  input  32  effective address (iadder)
store_data_in  input  32  rs2 value
bus_req_out  output  1  data-bus request
bus_we_out  output  1  1 = write
bus_addr_out  output  32  word-aligned address ({addr[31:2],2'b00})
bus_wdata_out  output  32  lane-replicated store data
bus_wstrb_out  output  4  byte strobes
bus_gnt_in  input  1  request accepted
bus_rvalid_in  input  1  response valid (loads and stores)
bus_rdata_in  input  32  read data
bus_err_in  input  1  error, qualified by bus_rvalid_in
stall_out  output  1  hold PC/pipeline
ld_data_out  output  32  extended load result
ld_valid_out  output  1  one-cycle pulse, ld_data_out valid
load_fault_out  output  1  one-cycle load access-fault pulse
store_fault_out  output  1  one-cycle store access-fault pulse

Behaviour:
- Reset: state IDLE. All outputs 0, including captured addr/size/data/we registers.
- start = (is_load_in | is_store_in) & ~misaligned_load_in & ~misaligned_store_in & ~trap_taken_in.
- A misaligned access issues no bus request and no stall; the trap unit handles it.
- States:
  - IDLE: on start, capture addr, size, unsigned, store data and we = is_store_in, then go to REQ.
  - REQ: bus_req_out = 1; address, we, wdata and wstrb are held stable from registers until grant. On bus_gnt_in go to WAIT. If trap_taken_in is asserted without a grant, go to IDLE with no side effects. If trap_taken_in and bus_gnt_in arrive together, the grant wins: go to DRAIN.
  - WAIT: on bus_rvalid_in go to RESP. If trap_taken_in is asserted without rvalid, go to DRAIN.
  - DRAIN: wait for bus_rvalid_in, discard the response and raise no fault, then go to IDLE.
  - RESP (1 cycle): if the captured err is set, pulse load_fault_out or store_fault_out per we, with ld_valid_out = 0. Otherwise pulse ld_valid_out = 1 for loads only. Then go to IDLE. A new start is not accepted in RESP.
- stall_out = (IDLE & start) | REQ | WAIT | DRAIN. stall_out is 0 in RESP so the pipeline advances.
- Minimum load latency, gnt and rvalid each arriving in the first eligible cycle: request seen in cycle 0, REQ in cycle 1, WAIT in cycle 2, ld_valid_out in cycle 3.
- Store strobes and data:
  - SB: wstrb = 4'b0001 << addr[1:0]; wdata = {4{sd[7:0]}}.
  - SH: wstrb = 4'b0011 << {addr[1],1'b0}; wdata = {2{sd[15:0]}}.
  - SW: wstrb = 4'hF; wdata = sd.
  - Size 11 is treated as word.
  - Loads drive wstrb = 0.
- Load extraction: shifted = rdata >> {addr[1:0],3'b000}.
  - Byte: extend shifted[7:0] with bit 7, or with zero when unsigned.
  - Half: extend shifted[15:0] with bit 15, or with zero when unsigned.
  - Word: pass unchanged.
- rdata and err are registered on rvalid. ld_data_out holds its value until the next load response.
- bus_rvalid_in outside WAIT/DRAIN is ignored.
- Async reset mid-transaction returns to IDLE immediately; the interconnect is reset by the same rst_n_in.

Optional Feature:
LSU_TIMEOUT_EN
- Defined: a counter clears on entry to WAIT and increments each WAIT cycle. When it reaches TIMEOUT-1 without rvalid, the FSM takes the erroneous RESP path (fault pulse) and then enters DRAIN to absorb a late response; the stall is released in RESP. The counter is not active in REQ or DRAIN.
- Undefined: no counter is synthesised; WAIT waits indefinitely.

Test Plan:
- LB addr=0x1003, rdata=0x80FF_1234, gnt and rvalid immediate -> ld_data_out=0xFFFFFF80, ld_valid pulse in cycle 3, stall high for cycles 0-2.
- LHU addr=0x2002, rdata=0xBEEF_0000 -> ld_data_out=0x0000BEEF.
- SB addr=0x3001, sd=0x0000_00A5, gnt delayed 3 cycles -> req/addr=0x3000/wdata=0xA5A5A5A5/wstrb=0010 stable until gnt; no ld_valid.
- SW with rvalid+err -> store_fault_out pulse for 1 cycle, no ld_valid, then IDLE.
- LW in WAIT, trap_taken_in pulse, rvalid 2 cycles later -> DRAIN, no ld_valid/fault, stall drops after rvalid.
- misaligned_load_in=1 with is_load_in -> bus_req_out and stall_out stay 0. With LSU_TIMEOUT_EN and TIMEOUT=4, no rvalid -> load_fault_out after 4 WAIT cycles.
